// File: rtl/riscv_rf_pkg.sv
// Shared constants and helpers for the parametrised register file with scoreboard.
package riscv_rf_pkg;

  localparam int RF_XLEN = 32;
  localparam int RF_NREG = 32;
  localparam int RF_NWR  = 4;
  localparam int RF_NRD  = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Low bit of lane p in a flat bus of w-bit lanes.
  function automatic int slice_lo(input int p, input int w);
    return p * w;
  endfunction

endpackage

// File: rtl/riscv_rf_wr_sel.sv
// Priority matcher: finds the lowest-indexed enabled write port hitting a target address.
module riscv_rf_wr_sel
  import riscv_rf_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int AW   = 5,
  parameter int NWR  = RF_NWR,
  localparam int IW  = (NWR > 1) ? clog2(NWR) : 1
) (
  input  logic [AW-1:0]       addr,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  output logic                hit,
  output logic [XLEN-1:0]     data,
  output logic [IW-1:0]       idx
);

  // Scan from the highest port down so the lowest matching port is written last and wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int p = NWR - 1; p >= 0; p--) begin
      if (wr_en[p] && (wr_addr[slice_lo(p, AW) +: AW] == addr)) begin
        hit  = 1'b1;
        data = wr_data[slice_lo(p, XLEN) +: XLEN];
        idx  = IW'(p);
      end
    end
  end

endmodule

// File: rtl/riscv_regfile_sb.sv
// Multi-port integer register file with per-register busy scoreboard and optional write bypass.
module riscv_regfile_sb
  import riscv_rf_pkg::*;
#(
  parameter int XLEN     = RF_XLEN,
  parameter int NREG     = RF_NREG,
  parameter int NWR      = RF_NWR,
  parameter int NRD      = RF_NRD,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = clog2(NREG)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                rsv_en_i,
  input  logic [AW-1:0]       rsv_addr_i,
  input  logic                flush_i,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  output logic [NREG-1:0]     busy_o
);

  localparam int IW = (NWR > 1) ? clog2(NWR) : 1;

  logic [XLEN-1:0] mem_reg  [NREG];
  logic [XLEN-1:0] mem_next [NREG];
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;

  genvar gi;

  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      logic            hit;
      logic [XLEN-1:0] data;
      logic [IW-1:0]   idx_unused;

      riscv_rf_wr_sel #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_sel (
        .addr   (AW'(gi)),
        .wr_en  (wr_en_i),
        .wr_addr(wr_addr_i),
        .wr_data(wr_data_i),
        .hit    (hit),
        .data   (data),
        .idx    (idx_unused)
      );

      if (ZERO_REG && (gi == 0)) begin : g_zero
        assign mem_next[gi]  = '0;
        assign busy_next[gi] = 1'b0;
      end else begin : g_live
        assign mem_next[gi] = hit ? data : mem_reg[gi];
        // Reserve is applied last so a new producer survives a same-cycle retire or flush.
        assign busy_next[gi] = (rsv_en_i && (rsv_addr_i == AW'(gi))) ? 1'b1 :
                               (hit || flush_i)                      ? 1'b0 :
                                                                       busy_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) mem_reg[i] <= '0;
      busy_reg <= '0;
    end else begin
      mem_reg  <= mem_next;
      busy_reg <= busy_next;
    end
  end

  assign busy_o = busy_reg;

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   raddr;
      logic            hit;
      logic [XLEN-1:0] data;
      logic [IW-1:0]   idx_unused;
      logic [XLEN-1:0] rdata;
      logic            rbusy;

      assign raddr = rd_addr_i[slice_lo(gi, AW) +: AW];

      riscv_rf_wr_sel #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_byp (
        .addr   (raddr),
        .wr_en  (wr_en_i),
        .wr_addr(wr_addr_i),
        .wr_data(wr_data_i),
        .hit    (hit),
        .data   (data),
        .idx    (idx_unused)
      );

      always_comb begin
        rdata = mem_reg[raddr];
        rbusy = busy_reg[raddr];
        if (BYPASS && hit) begin
          rdata = data;
          rbusy = 1'b0;
        end
        if (ZERO_REG && (raddr == '0)) begin
          rdata = '0;
          rbusy = 1'b0;
        end
      end

      assign rd_data_o[slice_lo(gi, XLEN) +: XLEN] = rdata;
      assign rd_busy_o[gi]                         = rbusy;
    end
  endgenerate

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Directed bench for riscv_regfile_sb with default parameters (bypass on, x0 hardwired).
module tb_riscv_regfile_sb;
  import riscv_rf_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NWR  = 4;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                flush;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NREG-1:0]     busy;

  int passed = 0;
  int total  = 0;

  riscv_regfile_sb dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rsv_en_i  (rsv_en),
    .rsv_addr_i(rsv_addr),
    .flush_i   (flush),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data),
    .rd_busy_o (rd_busy),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    flush    = 1'b0;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en[p]                          = 1'b1;
    wr_addr[slice_lo(p, AW) +: AW]    = a;
    wr_data[slice_lo(p, XLEN) +: XLEN] = d;
  endtask

  task automatic set_rd(input int q, input logic [AW-1:0] a);
    rd_addr[slice_lo(q, AW) +: AW] = a;
  endtask

  function automatic logic [XLEN-1:0] rdat(input int q);
    return rd_data[slice_lo(q, XLEN) +: XLEN];
  endfunction

  initial begin
    rst_n   = 1'b0;
    rd_addr = '0;
    clr_inputs();
    tick();
    tick();
    rst_n = 1'b1;

    // Everything reads zero and idle after reset.
    chk("reset_busy_vec", busy, 32'h0);
    for (int a = 0; a < NREG; a++) begin
      set_rd(0, AW'(a));
      set_rd(1, AW'(NREG - 1 - a));
      #1;
      chk($sformatf("reset_rd0_data_r%0d", a), rdat(0), 32'h0);
      chk($sformatf("reset_rd1_data_r%0d", NREG - 1 - a), rdat(1), 32'h0);
      chk($sformatf("reset_rd_busy_r%0d", a), {30'h0, rd_busy}, 32'h0);
    end
    $display("txn reset: all registers zero and idle");

    // Two ports colliding on r5: port 0 must win, both bypassed and stored.
    set_wr(0, 5'd5, 32'h11111111);
    set_wr(2, 5'd5, 32'h22222222);
    set_rd(0, 5'd5);
    set_rd(1, 5'd6);
    #1;
    chk("collide_bypass_r5", rdat(0), 32'h11111111);
    chk("collide_other_r6", rdat(1), 32'h0);
    tick();
    clr_inputs();
    #1;
    chk("collide_stored_r5", rdat(0), 32'h11111111);
    $display("txn write-collision r5: wr0=11111111 wr2=22222222");

    // Reserve r7; same-cycle reserve is not visible on rd_busy.
    rsv_en   = 1'b1;
    rsv_addr = 5'd7;
    set_rd(0, 5'd7);
    set_rd(1, 5'd5);
    #1;
    chk("rsv_same_cycle_busy", {31'h0, rd_busy[0]}, 32'h0);
    tick();
    clr_inputs();
    #1;
    chk("rsv_busy_vec", busy, 32'h0000_0080);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rsv_hold_busy_c%0d", c), {31'h0, rd_busy[0]}, 32'h1);
      chk($sformatf("rsv_hold_port1_c%0d", c), {31'h0, rd_busy[1]}, 32'h0);
      tick();
    end
    set_wr(1, 5'd7, 32'hDEADBEEF);
    #1;
    chk("wb_bypass_data_r7", rdat(0), 32'hDEADBEEF);
    chk("wb_bypass_busy_r7", {31'h0, rd_busy[0]}, 32'h0);
    chk("wb_reg_busy_still_set", busy, 32'h0000_0080);
    tick();
    clr_inputs();
    #1;
    chk("wb_busy_cleared", busy, 32'h0);
    chk("wb_stored_r7", rdat(0), 32'hDEADBEEF);
    chk("wb_r5_intact", rdat(1), 32'h11111111);
    $display("txn reserve r7, hold 3, writeback DEADBEEF");

    // Reserve r9, then reserve and write r9 together: reserve wins.
    rsv_en   = 1'b1;
    rsv_addr = 5'd9;
    tick();
    chk("r9_first_rsv", busy, 32'h0000_0200);
    set_wr(0, 5'd9, 32'h5);
    set_rd(0, 5'd9);
    tick();
    clr_inputs();
    #1;
    chk("r9_rsv_beats_write", busy, 32'h0000_0200);
    chk("r9_data", rdat(0), 32'h5);
    chk("r9_rd_busy", {31'h0, rd_busy[0]}, 32'h1);
    $display("txn reserve+write r9 same cycle: busy kept, data 5");

    // Reserve r3 then r4, then flush with a new reserve of r4.
    rsv_en   = 1'b1;
    rsv_addr = 5'd3;
    tick();
    rsv_addr = 5'd4;
    tick();
    chk("r3_r4_r9_busy", busy, 32'h0000_0218);
    flush    = 1'b1;
    rsv_addr = 5'd4;
    tick();
    clr_inputs();
    #1;
    chk("flush_keeps_r4_only", busy, 32'h0000_0010);
    $display("txn reserve r3,r4 then flush+reserve r4");

    // x0 ignores writes and reserves, including through the bypass path.
    set_wr(0, 5'd0, 32'hFFFFFFFF);
    rsv_en   = 1'b1;
    rsv_addr = 5'd0;
    set_rd(0, 5'd0);
    set_rd(1, 5'd4);
    #1;
    chk("x0_bypass_data", rdat(0), 32'h0);
    chk("x0_bypass_busy", {31'h0, rd_busy[0]}, 32'h0);
    tick();
    clr_inputs();
    #1;
    chk("x0_stored_data", rdat(0), 32'h0);
    chk("x0_busy_vec", busy, 32'h0000_0010);
    chk("r4_rd_busy", {31'h0, rd_busy[1]}, 32'h1);
    $display("txn write/reserve x0 ignored");

    // Write then reserve r12, then reset with competing write/reserve/flush.
    set_wr(3, 5'd12, 32'h0000ABCD);
    tick();
    clr_inputs();
    rsv_en   = 1'b1;
    rsv_addr = 5'd12;
    set_rd(0, 5'd12);
    set_rd(1, 5'd5);
    tick();
    clr_inputs();
    #1;
    chk("r12_before_reset_data", rdat(0), 32'h0000ABCD);
    chk("r12_before_reset_busy", busy, 32'h0000_1010);
    rst_n    = 1'b0;
    set_wr(1, 5'd12, 32'h00001234);
    rsv_en   = 1'b1;
    rsv_addr = 5'd12;
    tick();
    rst_n = 1'b1;
    clr_inputs();
    #1;
    chk("post_reset_r12_data", rdat(0), 32'h0);
    chk("post_reset_r5_data", rdat(1), 32'h0);
    chk("post_reset_busy_vec", busy, 32'h0);
    chk("post_reset_rd_busy", {30'h0, rd_busy}, 32'h0);
    $display("txn reset during reservation of r12");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/riscv_regfile_sb.md
Name: riscv_regfile_sb

Overview:
Parametrised multi-port integer register file with an integrated busy-bit scoreboard, successor to the fixed 4-write/2-read core regfile.
- Adds configurable width, depth and port counts.
- Adds optional write-to-read bypass.
- Tracks per-register pending-producer state (reserve at issue, clear on writeback, global flush) so issue logic can stall on RAW hazards from multi-cycle units (load, mul/div).
- Sits between decode/issue and the execute/writeback stages of the rv32im core.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (power of 2, >=2); AW = clog2(NREG)
NWR, 4, number of write ports
NRD, 2, number of read ports
BYPASS, 1, 1 = read ports return same-cycle write data; 0 = read returns stored value only
ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  synchronous active-low reset
wr_en_i  in  NWR  per-port write enable
wr_addr_i  in  NWR*AW  write addresses, port p at [p*AW +: AW]
wr_data_i  in  NWR*XLEN  write data, port p at [p*XLEN +: XLEN]
rsv_en_i  in  1  reserve request: mark rsv_addr_i busy
rsv_addr_i  in  AW  register to reserve
flush_i  in  1  clear all busy bits (pipeline flush)
rd_addr_i  in  NRD*AW  read addresses
rd_data_o  out  NRD*XLEN  read data, combinational
rd_busy_o  out  NRD  busy flag of each read address, combinational
busy_o  out  NREG  full scoreboard vector (registered)

Interface decision: one clock; reset is synchronous and active-low.

Behaviour:
- Reset (rst_ni=0 at rising edge):
  - all registers become 0, all busy bits become 0.
  - Reset overrides writes, reserve and flush in the same cycle.
  - After reset, rd_data_o=0, rd_busy_o=0 and busy_o=0 until the first write or reserve.
- Write:
  - Register r takes the data of the lowest-indexed port p with wr_en_i[p]=1 and wr_addr_i[p]=r.
  - Higher-indexed colliding ports are dropped.
  - Latency: visible in storage one cycle after the edge.
- ZERO_REG=1:
  - writes and reserves to address 0 are ignored.
  - reads of address 0 return 0 with busy 0, including on the bypass path.
- Read:
  - Asynchronous. rd_data_o[q] = storage[rd_addr_i[q]].
  - If BYPASS=1 and any write port targets rd_addr_i[q] this cycle, return that write data instead, using the same lowest-index priority as storage.
- Busy next-state per register r, evaluated in this order:
  1. Start from the current bit.
  2. Any write enable to r clears it.
  3. flush_i clears it.
  4. rsv_en_i with rsv_addr_i=r sets it.
- Net rules:
  - Reserve wins over a simultaneous write or flush to the same register (new producer issued while the old one retires).
  - Reserving an already-busy register keeps it busy (no counting; single outstanding producer per register).
- rd_busy_o[q]:
  - BYPASS=1: equals busy[rd_addr_i[q]] AND NOT (any write to that address this cycle).
  - BYPASS=0: equals the registered busy bit.
  - Never reflects a same-cycle reserve.
- Writes to non-busy registers are legal (single-cycle ALU results) and leave busy at 0.
- Out-of-range addresses cannot occur because NREG = 2^AW.
- No X propagation: storage is fully reset.

Decomposition:
- Package riscv_rf_pkg holds:
  - default XLEN/NREG/NWR/NRD constants.
  - a clog2 function.
  - a port-slice helper function used by both RTL and bench.
- Sub-module riscv_rf_wr_sel:
  - parametrised NWR-input priority matcher.
  - Given a target address and all write ports, outputs hit, winning data and winning index.
  - Instantiated once per register for storage and once per read port for bypass.

Test Plan:
- Reset then read all addresses -> rd_data_o=0, rd_busy_o=0, busy_o=0.
- Same cycle: wr0 r5=0x11111111 and wr2 r5=0x22222222 -> r5 reads 0x11111111 next cycle. With BYPASS=1, the same-cycle read of r5 returns 0x11111111.
- Reserve r7, hold 3 cycles, then wr1 r7=0xDEADBEEF:
  - rd_busy_o=1 during the hold.
  - In the write cycle with BYPASS=1: busy=0, data=0xDEADBEEF.
  - busy_o[7]=0 afterwards.
- Reserve r9 and write r9=0x5 in the same cycle while busy -> busy_o[9]=1 next cycle, data=0x5.
- Reserve r3 and r4 on successive cycles, then flush_i with rsv r4 -> busy_o[3]=0, busy_o[4]=1.
- Write x0=0xFFFFFFFF and reserve x0 -> reads 0, busy 0. Then assert rst_ni=0 mid-reservation of r12 -> r12=0, busy_o[12]=0.
